// File: rtl/ref_slew_limiter.sv
// ref_slew_limiter: rate-limits the step generator's setpoint before it reaches
// the control loop. ref_out walks toward the registered target by at most
// RAMP_STEP every RAMP_DIV enabled clocks, never overshooting and never wrapping.
// Direction/settled flags are decoded from a one-hot state register that lags
// ref_out by one cycle.
module ref_slew_limiter #(
    parameter int BIT_WIDTH   = 21,
    parameter int PRESC_WIDTH = 16,
    parameter int RAMP_DIV    = 100,
    parameter int RAMP_STEP   = 1,
    parameter int INIT_VAL    = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_WIDTH-1:0] target,
    input  logic                 enable,
    input  logic                 freeze,
    output logic [BIT_WIDTH-1:0] ref_out,
    output logic                 ramp_up,
    output logic                 ramp_down,
    output logic                 settled
);

    localparam logic [PRESC_WIDTH-1:0] PRESC_LAST = PRESC_WIDTH'(RAMP_DIV - 1);
    localparam logic [BIT_WIDTH:0]     STEP_EXT   = (BIT_WIDTH + 1)'(RAMP_STEP);
    localparam logic [BIT_WIDTH-1:0]   INIT_REF   = BIT_WIDTH'(INIT_VAL);

    typedef enum logic [2:0] {
        ST_SETTLED = 3'b001,
        ST_UP      = 3'b010,
        ST_DOWN    = 3'b100
    } ramp_state_t;

    logic [BIT_WIDTH-1:0]   target_q;
    logic [PRESC_WIDTH-1:0] presc;
    logic                   tick;
    logic [BIT_WIDTH:0]     sum_up;
    logic [BIT_WIDTH-1:0]   diff_down;
    logic [BIT_WIDTH-1:0]   ref_next;
    ramp_state_t            state;
    ramp_state_t            state_next;

    // Register the incoming setpoint every cycle regardless of enable/freeze
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= INIT_REF;
        end else begin
            target_q <= target;
        end
    end

    // Prescaler: cleared while disabled, held while frozen, wraps at RAMP_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (!enable) begin
            presc <= '0;
        end else if (!freeze) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESC_WIDTH'(1);
            end
        end
    end

    // One ramp tick on the last prescaler count of an enabled, unfrozen cycle
    always_comb begin
        tick = enable & ~freeze & (presc == PRESC_LAST);
    end

    // Candidate next reference: one step toward target_q, clamped onto it
    always_comb begin
        sum_up    = '0;
        diff_down = '0;
        ref_next  = ref_out;
        if (target_q > ref_out) begin
            sum_up = {1'b0, ref_out} + STEP_EXT;
            if (sum_up >= {1'b0, target_q}) begin
                ref_next = target_q;
            end else begin
                ref_next = sum_up[BIT_WIDTH-1:0];
            end
        end else if (target_q < ref_out) begin
            diff_down = ref_out - target_q;
            if ({1'b0, diff_down} <= STEP_EXT) begin
                ref_next = target_q;
            end else begin
                ref_next = ref_out - STEP_EXT[BIT_WIDTH-1:0];
            end
        end
    end

    // Reference output only moves on a tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_out <= INIT_REF;
        end else if (tick) begin
            ref_out <= ref_next;
        end
    end

    // Ramp state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SETTLED;
        end else begin
            state <= state_next;
        end
    end

    // Next ramp state from the current target_q/ref_out relation
    always_comb begin
        state_next = ST_SETTLED;
        if (target_q > ref_out) begin
            state_next = ST_UP;
        end else if (target_q < ref_out) begin
            state_next = ST_DOWN;
        end
    end

    assign ramp_up   = (state == ST_UP);
    assign ramp_down = (state == ST_DOWN);
    assign settled   = (state == ST_SETTLED);

endmodule
